// File: rtl/hazard_pkg.sv
// Shared definitions for the branch/hazard controller: compare opcodes and FSM states.
package hazard_pkg;

    localparam int OP_BEQ = 5'b01000;
    localparam int OP_BGT = 5'b01001;
    localparam int OP_BLT = 5'b01010;
    localparam int OP_BNE = 5'b01011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2
    } hz_state_t;

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Execute/Decode-side view of the branch/hazard controller: pipeline inputs and PC/flush/stall outputs.
interface branch_hazard_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
);
    logic              branchE;
    logic [OP_W-1:0]   opCode;
    logic [DATA_W-1:0] opeA;
    logic [DATA_W-1:0] opeB;
    logic              memReadE;
    logic [REG_W-1:0]  rdE;
    logic [REG_W-1:0]  rs1D;
    logic [REG_W-1:0]  rs2D;
    logic              select_pc;
    logic              flush;
    logic              stall;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output branchE, opCode, opeA, opeB, memReadE, rdE, rs1D, rs2D,
        input  select_pc, flush, stall, taken_cnt
    );

    modport slave (
        input  branchE, opCode, opeA, opeB, memReadE, rdE, rs1D, rs2D,
        output select_pc, flush, stall, taken_cnt
    );
endinterface

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator for the four compare opcodes.
module branch_cmp
    import hazard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 5,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] ope_a,
    input  logic [DATA_W-1:0] ope_b,
    output logic              cond
);

    logic gt;
    logic lt;

    generate
        if (SIGNED_CMP) begin : g_signed
            assign gt = $signed(ope_a) > $signed(ope_b);
            assign lt = $signed(ope_a) < $signed(ope_b);
        end else begin : g_unsigned
            assign gt = ope_a > ope_b;
            assign lt = ope_a < ope_b;
        end
    endgenerate

    // Unknown opcodes never resolve as taken.
    always_comb begin
        cond = 1'b0;
        case (opcode)
            OP_W'(OP_BEQ): cond = (ope_a == ope_b);
            OP_W'(OP_BGT): cond = gt;
            OP_W'(OP_BLT): cond = lt;
            OP_W'(OP_BNE): cond = (ope_a != ope_b);
            default:       cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch resolution and load-use hazard controller: drives PC select, multi-cycle flush and stall.
module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 5,
    parameter int REG_W       = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int LOAD_LAT    = 1,
    parameter bit SIGNED_CMP  = 1'b1,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst,
    branch_hazard_ctrl_if.slave bus
);

    localparam logic [15:0] FLUSH_LOAD = (FLUSH_DEPTH > 1) ? 16'(FLUSH_DEPTH - 2) : 16'd0;
    localparam logic [15:0] STALL_LOAD = (LOAD_LAT > 1)    ? 16'(LOAD_LAT - 2)    : 16'd0;

    hz_state_t        state_reg;
    logic [15:0]      cnt_reg;
    logic [CNT_W-1:0] taken_cnt_reg;
    logic             cond;
    logic             taken;
    logic             hazard;

    branch_cmp #(
        .DATA_W     (DATA_W),
        .OP_W       (OP_W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .opcode (bus.opCode),
        .ope_a  (bus.opeA),
        .ope_b  (bus.opeB),
        .cond   (cond)
    );

    // Branches seen during FLUSH are squashed bubbles and must not redirect the PC.
    assign taken  = !rst && bus.branchE && cond && (state_reg != FLUSH);
    assign hazard = bus.memReadE && (bus.rdE != REG_W'(0)) &&
                    ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));

    // Outputs are combinational so the redirect and first flush/stall cycle land in the resolve cycle.
    assign bus.select_pc = taken;
    assign bus.flush     = !rst && (taken || (state_reg == FLUSH));
    assign bus.stall     = !rst && !taken &&
                           (((state_reg == IDLE) && hazard) || (state_reg == STALL));
    assign bus.taken_cnt = rst ? '0 : taken_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            taken_cnt_reg <= '0;
        end else begin
            if (taken && (taken_cnt_reg != '1)) begin
                taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (taken) begin
                        if (FLUSH_DEPTH > 1) begin
                            state_reg <= FLUSH;
                            cnt_reg   <= FLUSH_LOAD;
                        end
                    end else if (hazard && (LOAD_LAT > 1)) begin
                        state_reg <= STALL;
                        cnt_reg   <= STALL_LOAD;
                    end
                end
                FLUSH: begin
                    if (cnt_reg == 16'd0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                STALL: begin
                    // A taken branch squashes the stalled consumer and restarts as a flush.
                    if (taken) begin
                        if (FLUSH_DEPTH > 1) begin
                            state_reg <= FLUSH;
                            cnt_reg   <= FLUSH_LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (cnt_reg == 16'd0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench: two controllers (signed/16-bit counter and unsigned/2-bit counter) share one stimulus stream.
module tb_branch_hazard_ctrl;

    logic clk;
    logic rst;

    int checks;
    int errors;

    branch_hazard_ctrl_if #(.DATA_W(32), .OP_W(5), .REG_W(4), .CNT_W(16)) bus_a ();
    branch_hazard_ctrl_if #(.DATA_W(32), .OP_W(5), .REG_W(4), .CNT_W(2))  bus_b ();

    branch_hazard_ctrl #(
        .DATA_W(32), .OP_W(5), .REG_W(4), .FLUSH_DEPTH(2), .LOAD_LAT(2),
        .SIGNED_CMP(1'b1), .CNT_W(16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    branch_hazard_ctrl #(
        .DATA_W(32), .OP_W(5), .REG_W(4), .FLUSH_DEPTH(2), .LOAD_LAT(2),
        .SIGNED_CMP(1'b0), .CNT_W(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    assign bus_b.branchE  = bus_a.branchE;
    assign bus_b.opCode   = bus_a.opCode;
    assign bus_b.opeA     = bus_a.opeA;
    assign bus_b.opeB     = bus_a.opeB;
    assign bus_b.memReadE = bus_a.memReadE;
    assign bus_b.rdE      = bus_a.rdE;
    assign bus_b.rs1D     = bus_a.rs1D;
    assign bus_b.rs2D     = bus_a.rs2D;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end else begin
            $display("ok   %s: got %0h", tag, actual);
        end
    endtask

    // Outputs packed as {select_pc, flush, stall}.
    task automatic exp_out(input string tag, input logic [2:0] exp_a, input logic [2:0] exp_b);
        check({tag, " a.sel/flush/stall"}, {29'd0, bus_a.select_pc, bus_a.flush, bus_a.stall}, {29'd0, exp_a});
        check({tag, " b.sel/flush/stall"}, {29'd0, bus_b.select_pc, bus_b.flush, bus_b.stall}, {29'd0, exp_b});
    endtask

    task automatic exp_cnt(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b);
        check({tag, " a.taken_cnt"}, {16'd0, bus_a.taken_cnt}, exp_a);
        check({tag, " b.taken_cnt"}, {30'd0, bus_b.taken_cnt}, exp_b);
    endtask

    task automatic set_br(input logic br, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_a.branchE = br;
        bus_a.opCode  = op;
        bus_a.opeA    = a;
        bus_a.opeB    = b;
    endtask

    task automatic set_ld(input logic mr, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        bus_a.memReadE = mr;
        bus_a.rdE      = rd;
        bus_a.rs1D     = rs1;
        bus_a.rs2D     = rs2;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        set_ld(1'b0, 4'd0, 4'd0, 4'd0);

        // Reset held for two cycles.
        settle();
        exp_out("reset", 3'b000, 3'b000);
        next();
        next();
        rst = 1'b0;
        settle();
        exp_out("idle", 3'b000, 3'b000);
        exp_cnt("idle", 0, 0);

        // BEQ equal: select one cycle, flush two cycles.
        next();
        set_br(1'b1, 5'b01000, 32'h5c, 32'h5c);
        settle();
        exp_out("beq eq c0", 3'b110, 3'b110);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        exp_out("beq eq c1", 3'b010, 3'b010);
        exp_cnt("beq eq", 1, 1);
        next();
        settle();
        exp_out("beq eq c2", 3'b000, 3'b000);

        // BEQ unequal.
        next();
        set_br(1'b1, 5'b01000, 32'h55, 32'h5c);
        settle();
        exp_out("beq ne", 3'b000, 3'b000);

        // BGT 0x60 > 0x5c under both compare modes.
        next();
        set_br(1'b1, 5'b01001, 32'h60, 32'h5c);
        settle();
        exp_out("bgt", 3'b110, 3'b110);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        exp_out("bgt flush", 3'b010, 3'b010);
        next();

        // BLT -1 < 1 only when signed.
        set_br(1'b1, 5'b01010, 32'hffff_ffff, 32'h1);
        settle();
        exp_out("blt sign", 3'b110, 3'b000);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        exp_out("blt flush", 3'b010, 3'b000);
        exp_cnt("blt", 3, 2);
        next();

        // Back-to-back: second branch lands inside FLUSH and is ignored.
        set_br(1'b1, 5'b01011, 32'h1, 32'h2);
        settle();
        exp_out("b2b c0", 3'b110, 3'b110);
        next();
        settle();
        exp_out("b2b c1", 3'b010, 3'b010);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        exp_out("b2b c2", 3'b000, 3'b000);
        exp_cnt("b2b", 4, 3);

        // Fifth taken branch: 2-bit counter stays saturated.
        next();
        set_br(1'b1, 5'b01011, 32'h7, 32'h2);
        settle();
        exp_out("sat", 3'b110, 3'b110);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        next();
        settle();
        exp_cnt("sat", 5, 3);

        // Load-use on rs2: stall exactly two cycles.
        next();
        set_ld(1'b1, 4'd3, 4'd0, 4'd3);
        settle();
        exp_out("ld c0", 3'b001, 3'b001);
        next();
        set_ld(1'b0, 4'd0, 4'd0, 4'd0);
        settle();
        exp_out("ld c1", 3'b001, 3'b001);
        next();
        settle();
        exp_out("ld c2", 3'b000, 3'b000);

        // rdE = x0 never hazards.
        next();
        set_ld(1'b1, 4'd0, 4'd0, 4'd0);
        settle();
        exp_out("ld x0", 3'b000, 3'b000);

        // Taken branch on second stall cycle overrides the stall.
        next();
        set_ld(1'b1, 4'd5, 4'd5, 4'd1);
        settle();
        exp_out("ldbr c0", 3'b001, 3'b001);
        next();
        set_ld(1'b0, 4'd0, 4'd0, 4'd0);
        set_br(1'b1, 5'b01000, 32'h9, 32'h9);
        settle();
        exp_out("ldbr c1", 3'b110, 3'b110);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        exp_out("ldbr c2", 3'b010, 3'b010);
        next();
        settle();
        exp_out("ldbr c3", 3'b000, 3'b000);
        exp_cnt("ldbr", 6, 3);

        // Simultaneous taken and hazard: flush wins; hazard ignored during FLUSH.
        next();
        set_ld(1'b1, 4'd2, 4'd2, 4'd0);
        set_br(1'b1, 5'b01000, 32'h1, 32'h1);
        settle();
        exp_out("both c0", 3'b110, 3'b110);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        exp_out("both c1", 3'b010, 3'b010);
        next();
        set_ld(1'b0, 4'd0, 4'd0, 4'd0);
        settle();
        exp_out("both c2", 3'b000, 3'b000);
        exp_cnt("both", 7, 3);

        // Reset during FLUSH aborts the flush.
        next();
        set_br(1'b1, 5'b01000, 32'h3, 32'h3);
        settle();
        exp_out("rstf c0", 3'b110, 3'b110);
        next();
        set_br(1'b0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1;
        settle();
        exp_out("rstf c1", 3'b000, 3'b000);
        exp_cnt("rstf c1", 0, 0);
        next();
        rst = 1'b0;
        settle();
        exp_out("rstf c2", 3'b000, 3'b000);
        exp_cnt("rstf c2", 0, 0);

        // Reset during STALL aborts the stall.
        next();
        set_ld(1'b1, 4'd4, 4'd4, 4'd0);
        settle();
        exp_out("rsts c0", 3'b001, 3'b001);
        next();
        set_ld(1'b0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        next();
        rst = 1'b0;
        settle();
        exp_out("rsts c2", 3'b000, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
